// File: rtl/core24_pkg.sv
// Shared definitions for the 24-bit core: datapath width, ALU opcodes and
// the control bundle that travels with an instruction into execute.
package core24_pkg;

  localparam int DATA_W      = 24;
  localparam int CORE_REG_AW = 4;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_MUL  = 3'd1;
  localparam logic [2:0] ALU_PASS = 3'd2;
  localparam logic [2:0] ALU_ADDR = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_LUI  = 3'd5;
  localparam logic [2:0] ALU_SHR  = 3'd6;

  typedef struct packed {
    logic [2:0]             aluop;
    logic [CORE_REG_AW-1:0] rd;
    logic                   we;
    logic                   mem_rd;
    logic                   mem_wr;
    logic                   beq;
  } ex_ctrl_t;

endpackage

// File: rtl/id_ex_entry.sv
// One decode/execute pipeline entry: operands, store data and control.
// Load captures new contents, clear zeroes the entry (clear wins).
// Build option ID_EX_FWD_EN: entry also keeps rs1/rs2/use_imm and snoops the
// writeback port, both on the load path and while holding.
module id_ex_entry
  import core24_pkg::*;
#(
  parameter int REG_AW = CORE_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] d_a,
  input  logic [DATA_W-1:0] d_b,
  input  logic [DATA_W-1:0] d_sd,
  input  ex_ctrl_t          d_ctrl,
`ifdef ID_EX_FWD_EN
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic              d_use_imm,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] q_rs1,
  output logic [REG_AW-1:0] q_rs2,
  output logic              q_use_imm,
`endif
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b,
  output logic [DATA_W-1:0] q_sd,
  output ex_ctrl_t          q_ctrl
);

`ifdef ID_EX_FWD_EN
  logic [DATA_W-1:0] nxt_a, nxt_b, nxt_sd;
  logic [REG_AW-1:0] nxt_rs1, nxt_rs2;
  logic              nxt_use_imm;
  ex_ctrl_t          nxt_ctrl;

  // Pick incoming or held contents, then let a matching writeback override them.
  always_comb begin
    nxt_a       = load ? d_a       : q_a;
    nxt_b       = load ? d_b       : q_b;
    nxt_sd      = load ? d_sd      : q_sd;
    nxt_rs1     = load ? d_rs1     : q_rs1;
    nxt_rs2     = load ? d_rs2     : q_rs2;
    nxt_use_imm = load ? d_use_imm : q_use_imm;
    nxt_ctrl    = load ? d_ctrl    : q_ctrl;
    if (wb_we && (wb_rd == nxt_rs1)) begin
      nxt_a = wb_data;
    end
    if (wb_we && (wb_rd == nxt_rs2)) begin
      nxt_sd = wb_data;
      if (!nxt_use_imm) begin
        nxt_b = wb_data;
      end
    end
  end

  // Entry register; updates every cycle so held operands track writebacks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a       <= '0;
      q_b       <= '0;
      q_sd      <= '0;
      q_rs1     <= '0;
      q_rs2     <= '0;
      q_use_imm <= 1'b0;
      q_ctrl    <= '0;
    end else if (clr) begin
      q_a       <= '0;
      q_b       <= '0;
      q_sd      <= '0;
      q_rs1     <= '0;
      q_rs2     <= '0;
      q_use_imm <= 1'b0;
      q_ctrl    <= '0;
    end else begin
      q_a       <= nxt_a;
      q_b       <= nxt_b;
      q_sd      <= nxt_sd;
      q_rs1     <= nxt_rs1;
      q_rs2     <= nxt_rs2;
      q_use_imm <= nxt_use_imm;
      q_ctrl    <= nxt_ctrl;
    end
  end
`else
  // Entry register; contents captured as presented and held until replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a    <= '0;
      q_b    <= '0;
      q_sd   <= '0;
      q_ctrl <= '0;
    end else if (clr) begin
      q_a    <= '0;
      q_b    <= '0;
      q_sd   <= '0;
      q_ctrl <= '0;
    end else if (load) begin
      q_a    <= d_a;
      q_b    <= d_b;
      q_sd   <= d_sd;
      q_ctrl <= d_ctrl;
    end
  end
`endif

endmodule

// File: rtl/id_ex_stage24.sv
// Decode-to-execute stage: MAIN entry drives execute, SKID absorbs one
// instruction of back-pressure so in_ready never depends on ex_ready.
// Build option ID_EX_FWD_EN enables writeback-to-operand forwarding.
//
// state | meaning
// EMPTY | no valid entries
// ONE   | MAIN valid, SKID empty
// TWO   | MAIN and SKID valid, not accepting
module id_ex_stage24
  import core24_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_aluop,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_rs1_val,
  input  logic [DATA_W-1:0] in_rs2_val,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_we,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic              in_beq,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_A,
  output logic [DATA_W-1:0] ex_B,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [2:0]        ex_aluop,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_we,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic              ex_beq
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, state_nxt;
  logic accept, consume;
  logic main_load_in, main_load_skid, skid_load, skid_drain;

  ex_ctrl_t          in_ctrl, main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] main_d_a, main_d_b, main_d_sd;
  logic [DATA_W-1:0] skid_a, skid_b, skid_sd;

  assign accept  = in_valid && in_ready;
  assign consume = ex_valid && ex_ready;

  assign in_b = in_use_imm ? in_imm : in_rs2_val;

  // Pack incoming control bits into the shared bundle.
  always_comb begin
    in_ctrl        = '0;
    in_ctrl.aluop  = in_aluop;
    in_ctrl.rd     = in_rd;
    in_ctrl.we     = in_we;
    in_ctrl.mem_rd = in_mem_rd;
    in_ctrl.mem_wr = in_mem_wr;
    in_ctrl.beq    = in_beq;
  end

  // Steering of accepts/consumes into MAIN and SKID; flush overrides all of it.
  always_comb begin
    state_nxt      = state;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    skid_drain     = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_load_in = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_load_in = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_nxt = TWO;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            main_load_skid = 1'b1;
            skid_drain     = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      ex_valid <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      ex_valid <= (state_nxt != EMPTY);
      in_ready <= (state_nxt != TWO);
    end
  end

  assign main_d_a    = main_load_skid ? skid_a    : in_rs1_val;
  assign main_d_b    = main_load_skid ? skid_b    : in_b;
  assign main_d_sd   = main_load_skid ? skid_sd   : in_rs2_val;
  assign main_d_ctrl = main_load_skid ? skid_ctrl : in_ctrl;

`ifdef ID_EX_FWD_EN
  logic [REG_AW-1:0] skid_rs1, skid_rs2, main_rs1, main_rs2;
  logic              skid_use_imm, main_use_imm;
  logic              unused_main_rs;
  assign unused_main_rs = ^{main_rs1, main_rs2, main_use_imm};
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{in_rs1, in_rs2, wb_we, wb_rd, wb_data};
`endif

  id_ex_entry #(.REG_AW(REG_AW)) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .load      (main_load_in || main_load_skid),
    .d_a       (main_d_a),
    .d_b       (main_d_b),
    .d_sd      (main_d_sd),
    .d_ctrl    (main_d_ctrl),
`ifdef ID_EX_FWD_EN
    .d_rs1     (main_load_skid ? skid_rs1 : in_rs1),
    .d_rs2     (main_load_skid ? skid_rs2 : in_rs2),
    .d_use_imm (main_load_skid ? skid_use_imm : in_use_imm),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .q_rs1     (main_rs1),
    .q_rs2     (main_rs2),
    .q_use_imm (main_use_imm),
`endif
    .q_a       (ex_A),
    .q_b       (ex_B),
    .q_sd      (ex_store_data),
    .q_ctrl    (main_ctrl)
  );

  id_ex_entry #(.REG_AW(REG_AW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush || skid_drain),
    .load      (skid_load),
    .d_a       (in_rs1_val),
    .d_b       (in_b),
    .d_sd      (in_rs2_val),
    .d_ctrl    (in_ctrl),
`ifdef ID_EX_FWD_EN
    .d_rs1     (in_rs1),
    .d_rs2     (in_rs2),
    .d_use_imm (in_use_imm),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .q_rs1     (skid_rs1),
    .q_rs2     (skid_rs2),
    .q_use_imm (skid_use_imm),
`endif
    .q_a       (skid_a),
    .q_b       (skid_b),
    .q_sd      (skid_sd),
    .q_ctrl    (skid_ctrl)
  );

  assign ex_aluop  = main_ctrl.aluop;
  assign ex_rd     = main_ctrl.rd;
  assign ex_we     = main_ctrl.we;
  assign ex_mem_rd = main_ctrl.mem_rd;
  assign ex_mem_wr = main_ctrl.mem_wr;
  assign ex_beq    = main_ctrl.beq;

endmodule

// File: tb/tb_id_ex_stage24.sv
// Directed bench for id_ex_stage24: cycle table plus async-reset and
// (when ID_EX_FWD_EN is defined) forwarding sequences.
module tb_id_ex_stage24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_aluop;
  logic [3:0]  in_rs1, in_rs2, in_rd;
  logic [23:0] in_rs1_val, in_rs2_val, in_imm;
  logic        in_use_imm, in_we, in_mem_rd, in_mem_wr, in_beq;
  logic        flush, wb_we;
  logic [3:0]  wb_rd;
  logic [23:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [23:0] ex_A, ex_B, ex_store_data;
  logic [2:0]  ex_aluop;
  logic [3:0]  ex_rd;
  logic        ex_we, ex_mem_rd, ex_mem_wr, ex_beq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage24 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_rd(in_rd),
    .in_we(in_we), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_beq(in_beq),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_A(ex_A), .ex_B(ex_B), .ex_store_data(ex_store_data),
    .ex_aluop(ex_aluop), .ex_rd(ex_rd),
    .ex_we(ex_we), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_beq(ex_beq)
  );

  typedef struct {
    logic        iv, er, fl;
    logic [23:0] rs1v, rs2v, imm;
    logic        ui;
    logic [2:0]  op;
    logic [3:0]  rd;
    logic [3:0]  ctl;
    logic        ev, ir, chk;
    logic [23:0] ea, eb, esd;
    logic [2:0]  eop;
    logic [3:0]  erd;
    logic [3:0]  ectl;
  } vec_t;

  vec_t vec [16];

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ex_valid"}, {23'd0, ex_valid}, 24'd0);
    check({tag, " in_ready"}, {23'd0, in_ready}, 24'd1);
    check({tag, " ex_A"}, ex_A, 24'd0);
    check({tag, " ex_B"}, ex_B, 24'd0);
    check({tag, " ex_store_data"}, ex_store_data, 24'd0);
    check({tag, " ex_aluop"}, {21'd0, ex_aluop}, 24'd0);
    check({tag, " ex_rd"}, {20'd0, ex_rd}, 24'd0);
    check({tag, " ex_ctl"}, {20'd0, ex_we, ex_mem_rd, ex_mem_wr, ex_beq}, 24'd0);
  endtask

  task automatic drive(input logic iv, input logic [23:0] r1v, input logic [23:0] r2v,
                       input logic [23:0] imm, input logic ui, input logic [2:0] op,
                       input logic [3:0] rd, input logic [3:0] ctl);
    in_valid   = iv;
    in_rs1_val = r1v;
    in_rs2_val = r2v;
    in_imm     = imm;
    in_use_imm = ui;
    in_aluop   = op;
    in_rd      = rd;
    {in_we, in_mem_rd, in_mem_wr, in_beq} = ctl;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_ready = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = 4'd0; wb_data = 24'd0;
    in_rs1 = 4'd1; in_rs2 = 4'd2;
    drive(1'b0, 24'd0, 24'd0, 24'd0, 1'b0, 3'd0, 4'd0, 4'd0);

    //        iv er fl rs1v        rs2v        imm         ui op    rd    ctl      ev ir chk ea          eb          esd         eop   erd   ectl
    vec[0]  = '{1, 1, 0, 24'h000005, 24'h000007, 24'h000000, 0, 3'd0, 4'd1, 4'b1000, 1, 1, 1, 24'h000005, 24'h000007, 24'h000007, 3'd0, 4'd1, 4'b1000};
    vec[1]  = '{1, 1, 0, 24'h000000, 24'hFFFFFF, 24'h001200, 1, 3'd5, 4'd2, 4'b1000, 1, 1, 1, 24'h000000, 24'h001200, 24'hFFFFFF, 3'd5, 4'd2, 4'b1000};
    vec[2]  = '{0, 1, 0, 24'h000000, 24'h000000, 24'h000000, 0, 3'd0, 4'd0, 4'b0000, 0, 1, 0, 24'h0, 24'h0, 24'h0, 3'd0, 4'd0, 4'b0000};
    vec[3]  = '{1, 0, 0, 24'h000011, 24'h000021, 24'h000000, 0, 3'd4, 4'd3, 4'b0100, 1, 1, 1, 24'h000011, 24'h000021, 24'h000021, 3'd4, 4'd3, 4'b0100};
    vec[4]  = '{1, 0, 0, 24'h000012, 24'h000022, 24'h000000, 0, 3'd1, 4'd4, 4'b0010, 1, 0, 1, 24'h000011, 24'h000021, 24'h000021, 3'd4, 4'd3, 4'b0100};
    vec[5]  = '{1, 0, 0, 24'h000013, 24'h000023, 24'h000400, 1, 3'd6, 4'd5, 4'b0001, 1, 0, 1, 24'h000011, 24'h000021, 24'h000021, 3'd4, 4'd3, 4'b0100};
    vec[6]  = '{1, 1, 0, 24'h000013, 24'h000023, 24'h000400, 1, 3'd6, 4'd5, 4'b0001, 1, 1, 1, 24'h000012, 24'h000022, 24'h000022, 3'd1, 4'd4, 4'b0010};
    vec[7]  = '{1, 1, 0, 24'h000013, 24'h000023, 24'h000400, 1, 3'd6, 4'd5, 4'b0001, 1, 1, 1, 24'h000013, 24'h000400, 24'h000023, 3'd6, 4'd5, 4'b0001};
    vec[8]  = '{0, 1, 0, 24'h000000, 24'h000000, 24'h000000, 0, 3'd0, 4'd0, 4'b0000, 0, 1, 0, 24'h0, 24'h0, 24'h0, 3'd0, 4'd0, 4'b0000};
    vec[9]  = '{1, 0, 0, 24'h000041, 24'h000042, 24'h000000, 0, 3'd0, 4'd6, 4'b1000, 1, 1, 1, 24'h000041, 24'h000042, 24'h000042, 3'd0, 4'd6, 4'b1000};
    vec[10] = '{1, 0, 0, 24'h000051, 24'h000052, 24'h000000, 0, 3'd3, 4'd7, 4'b0100, 1, 0, 1, 24'h000041, 24'h000042, 24'h000042, 3'd0, 4'd6, 4'b1000};
    vec[11] = '{1, 0, 1, 24'h000066, 24'h000067, 24'h000000, 0, 3'd2, 4'd9, 4'b1000, 0, 1, 0, 24'h0, 24'h0, 24'h0, 3'd0, 4'd0, 4'b0000};
    vec[12] = '{0, 1, 0, 24'h000000, 24'h000000, 24'h000000, 0, 3'd0, 4'd0, 4'b0000, 0, 1, 0, 24'h0, 24'h0, 24'h0, 3'd0, 4'd0, 4'b0000};
    vec[13] = '{1, 1, 0, 24'h000077, 24'h000078, 24'h000000, 0, 3'd2, 4'd8, 4'b0010, 1, 1, 1, 24'h000077, 24'h000078, 24'h000078, 3'd2, 4'd8, 4'b0010};
    vec[14] = '{1, 1, 1, 24'h000088, 24'h000089, 24'h000000, 0, 3'd1, 4'd9, 4'b1000, 0, 1, 0, 24'h0, 24'h0, 24'h0, 3'd0, 4'd0, 4'b0000};
    vec[15] = '{0, 1, 0, 24'h000000, 24'h000000, 24'h000000, 0, 3'd0, 4'd0, 4'b0000, 0, 1, 0, 24'h0, 24'h0, 24'h0, 3'd0, 4'd0, 4'b0000};

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vec[i].iv, vec[i].rs1v, vec[i].rs2v, vec[i].imm, vec[i].ui,
            vec[i].op, vec[i].rd, vec[i].ctl);
      ex_ready = vec[i].er;
      flush    = vec[i].fl;
      @(posedge clk);
      #1;
      check($sformatf("v%0d ex_valid", i), {23'd0, ex_valid}, {23'd0, vec[i].ev});
      check($sformatf("v%0d in_ready", i), {23'd0, in_ready}, {23'd0, vec[i].ir});
      if (vec[i].chk) begin
        check($sformatf("v%0d ex_A", i), ex_A, vec[i].ea);
        check($sformatf("v%0d ex_B", i), ex_B, vec[i].eb);
        check($sformatf("v%0d ex_store_data", i), ex_store_data, vec[i].esd);
        check($sformatf("v%0d ex_aluop", i), {21'd0, ex_aluop}, {21'd0, vec[i].eop});
        check($sformatf("v%0d ex_rd", i), {20'd0, ex_rd}, {20'd0, vec[i].erd});
        check($sformatf("v%0d ex_ctl", i), {20'd0, ex_we, ex_mem_rd, ex_mem_wr, ex_beq},
              {20'd0, vec[i].ectl});
      end
    end

    // Async reset with both entries full: outputs clear without a clock edge.
    @(negedge clk);
    flush = 1'b0; ex_ready = 1'b0;
    drive(1'b1, 24'h0000AA, 24'h0000AB, 24'h0, 1'b0, 3'd4, 4'd3, 4'b1111);
    @(negedge clk);
    drive(1'b1, 24'h0000BA, 24'h0000BB, 24'h0, 1'b0, 3'd1, 4'd5, 4'b1010);
    @(negedge clk);
    drive(1'b0, 24'h0, 24'h0, 24'h0, 1'b0, 3'd0, 4'd0, 4'd0);
    check("full in_ready", {23'd0, in_ready}, 24'd0);
    check("full ex_A", ex_A, 24'h0000AA);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    ex_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst ex_valid", {23'd0, ex_valid}, 24'd0);

`ifdef ID_EX_FWD_EN
    // Held entry picks up a matching writeback on rs1, then on rs2.
    @(negedge clk);
    ex_ready = 1'b0;
    in_rs1 = 4'd3; in_rs2 = 4'd4;
    drive(1'b1, 24'h000001, 24'h000002, 24'h0, 1'b0, 3'd0, 4'd1, 4'b1000);
    @(posedge clk);
    #1;
    check("fwd cap ex_A", ex_A, 24'h000001);
    @(negedge clk);
    drive(1'b0, 24'h0, 24'h0, 24'h0, 1'b0, 3'd0, 4'd0, 4'd0);
    wb_we = 1'b1; wb_rd = 4'd3; wb_data = 24'hABCDEF;
    @(posedge clk);
    #1;
    check("fwd rs1 ex_A", ex_A, 24'hABCDEF);
    check("fwd rs1 ex_B", ex_B, 24'h000002);
    @(negedge clk);
    wb_rd = 4'd4; wb_data = 24'h123456;
    @(posedge clk);
    #1;
    check("fwd rs2 ex_B", ex_B, 24'h123456);
    check("fwd rs2 ex_store_data", ex_store_data, 24'h123456);
    @(negedge clk);
    ex_ready = 1'b1;
    in_rs1 = 4'd5; in_rs2 = 4'd6;
    drive(1'b1, 24'h000009, 24'h00000A, 24'h0, 1'b0, 3'd0, 4'd2, 4'b1000);
    wb_rd = 4'd5; wb_data = 24'h00FACE;
    @(posedge clk);
    #1;
    check("fwd capture ex_A", ex_A, 24'h00FACE);
    check("fwd capture ex_B", ex_B, 24'h00000A);
    @(negedge clk);
    wb_we = 1'b0;
    drive(1'b0, 24'h0, 24'h0, 24'h0, 1'b0, 3'd0, 4'd0, 4'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage24.md
# id_ex_stage24

Decode-to-execute pipeline stage for the 24-bit core. It accepts decoded instructions from the decoder over a valid/ready handshake and selects operand B (register or pre-shifted immediate). It presents registered operands, ALUop and writeback/memory control to the ALU, and contains a 2-entry skid buffer, branch flush, and optional writeback-to-operand forwarding.

## Interface
Parameters:
- REG_AW, default 4: register-address width.
- DATA_W, default 24: datapath width; only 24 is supported.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoder has an instruction.
- in_ready  out  1  stage can accept.
- in_aluop  in  3  ALU opcode (0 ADD, 1 MUL, 2 PASS, 3 ADDR, 4 OR, 5 LUI, 6 SHR).
- in_rs1, in_rs2  in  REG_AW  source register numbers.
- in_rs1_val, in_rs2_val  in  DATA_W  register-file read data.
- in_imm  in  DATA_W  immediate, already extended or shifted by the decoder.
- in_use_imm  in  1  B = imm when 1, else rs2 value.
- in_rd  in  REG_AW  destination register.
- in_we, in_mem_rd, in_mem_wr, in_beq  in  1 each  control bits.
- flush  in  1  taken branch; discard everything held.
- wb_we  in  1  writeback strobe (forwarding source).
- wb_rd  in  REG_AW  writeback register.
- wb_data  in  DATA_W  writeback value.
- ex_valid  out  1  ALU inputs are valid.
- ex_ready  in  1  downstream accepts.
- ex_A, ex_B  out  DATA_W  ALU operands.
- ex_store_data  out  DATA_W  rs2 value for STORE.
- ex_aluop  out  3  opcode.
- ex_rd  out  REG_AW  destination register.
- ex_we, ex_mem_rd, ex_mem_wr, ex_beq  out  1 each  control bits.

## Operation
- Two entries: MAIN drives the ex_* outputs; SKID holds one overflow instruction.
- Accept happens when in_valid && in_ready. Captured fields: A = rs1_val; B = use_imm ? imm : rs2_val; store_data = rs2_val; plus all control fields.
- in_ready = !SKID.valid. It is a registered condition with no combinational path from ex_ready.
- Accept while MAIN is empty, or while MAIN is being consumed (ex_valid && ex_ready): the new instruction goes to MAIN.
- Accept while MAIN is full and not consumed: the new instruction goes to SKID.
- MAIN consumed while SKID is valid: SKID moves to MAIN and SKID clears.
- States: EMPTY (no valid entries), ONE (MAIN valid), TWO (both valid). Transitions follow the accept/consume rules above. TWO never accepts.
- flush: at the next edge both entries become invalid and any same-cycle accept is discarded. Flush has priority over accept and consume. ex_valid is 0 from the following cycle.
- Ordering is strictly in order; no instruction is ever duplicated or dropped except by flush or reset.
- Arithmetic: none. Operands pass unmodified at 24 bits.

## Timing
- Latency is 1 cycle from accept to ex_valid; throughput is 1 instruction per cycle.
- Outputs after reset: ex_valid=0, in_ready=1, and every ex_* data and control output = 0.
- Reset asserted mid-operation clears all entries immediately (asynchronously). No flush is needed afterwards.
- ex_* outputs stay stable while ex_valid && !ex_ready.
- Boundary: in_valid with ex_ready=0 for 2 cycles fills the stage. in_ready drops in the cycle after the second accept.

## Configuration
- ID_EX_FWD_EN defined: forwarding is active, applied at capture and every held cycle.
  - If wb_we && wb_rd == rs1, A takes wb_data.
  - If wb_we && wb_rd == rs2, store_data takes wb_data, and B takes wb_data when use_imm=0.
  - At capture, wb_data takes priority over in_rs*_val.
  - Entries store rs1/rs2 for this purpose.
- ID_EX_FWD_EN undefined: no forwarding and no rs storage. Values are captured as presented, and software or the hazard unit ensures correctness.

## Structure
- Shared package `core24_pkg` holds the ALUop localparams (ALU_ADD through ALU_SHR), the DATA_W=24 constant, and the `ex_ctrl_t` struct (aluop, rd, we, mem_rd, mem_wr, beq).
- One sub-module, `id_ex_entry`: a single pipeline entry register with load, clear and optional forward-update. It is instantiated twice (MAIN, SKID).

## Test plan
- Reset then single ADD: rs1_val=5, rs2_val=7, use_imm=0 → one cycle later ex_valid=1, ex_A=5, ex_B=7, ex_aluop=0.
- Back-pressure: ex_ready=0 while issuing I1 and I2 → in_ready=0 after I2. Raise ex_ready → I1 then I2 appear in order, and I3 is not lost.
- LUI: imm=0x001200, use_imm=1, rs2_val=0xFFFFFF → ex_B=0x001200, ex_store_data=0xFFFFFF.
- Flush in TWO state together with in_valid → next cycle ex_valid=0 and in_ready=1, and the flushed or incoming instruction never emerges.
- ID_EX_FWD_EN: a held entry with rs1=3, ex_ready=0, and wb_we=1, wb_rd=3, wb_data=0xABCDEF → ex_A=0xABCDEF on the next cycle.
- Async reset pulse mid-stream with both entries full → ex_valid=0 and every ex_* output = 0 immediately, without waiting for clk.
